// File: rtl/i_decoder2_4_scan.sv
// Registered active-low 2**SIZE-way decoder with direct and automatic scan modes.
// Optional macro I_DECODER_BLANK_EN blanks y for the first cycle of every scan step.
module i_decoder2_4_scan #(
  parameter int SIZE = 2,
  parameter int DIV  = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   load,
  input  logic [SIZE-1:0]        idx,
  output logic [(1<<SIZE)-1:0]   y,
  output logic [SIZE-1:0]        cur,
  output logic                   wrap,
  output logic [1:0]             dbg_state
);

  localparam int N  = 1 << SIZE;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic [PW-1:0]   PSC_LAST = PW'(DIV - 1);
  localparam logic [SIZE-1:0] CUR_LAST = '1;
  localparam logic [N-1:0]    ONE_HOT0 = N'(1);

`ifdef I_DECODER_BLANK_EN
  if (DIV < 2) begin : g_div_check
    $error("i_decoder2_4_scan: DIV must be at least 2 when blanking is enabled");
  end
`endif

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] cur_q, cur_d;
  logic [PW-1:0]   psc_q, psc_d;
  logic [N-1:0]    y_q, y_d;
  logic            wrap_q, wrap_d;
  logic            stay_scan;
  logic            step;

  always_comb begin
    state_d = ST_IDLE;
    if (en) state_d = mode ? ST_SCAN : ST_DIRECT;

    // A step only happens while scanning continues; load wins over a coincident step.
    stay_scan = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    step      = stay_scan && (psc_q == PSC_LAST) && !load;

    cur_d = cur_q;
    if (load)      cur_d = idx;
    else if (step) cur_d = cur_q + 1'b1;

    psc_d = '0;
    if (stay_scan && !load && !step) psc_d = psc_q + 1'b1;

    wrap_d = step && (cur_q == CUR_LAST);

    y_d = '1;
    if (state_d != ST_IDLE) y_d = ~(ONE_HOT0 << cur_d);
`ifdef I_DECODER_BLANK_EN
    if ((state_d == ST_SCAN) && (psc_d == '0)) y_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      psc_q   <= '0;
      y_q     <= '1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      psc_q   <= psc_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y         = y_q;
  assign cur       = cur_q;
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i_decoder2_4_scan.sv
// Bench for i_decoder2_4_scan: directed test-plan items plus random traffic against a cycle model.
module tb_i_decoder2_4_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [1:0] idx;
  logic [3:0] y;
  logic [1:0] cur;
  logic       wrap;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

`ifdef I_DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  i_decoder2_4_scan #(.SIZE(2), .DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .idx(idx),
    .y(y), .cur(cur), .wrap(wrap), .dbg_state(dbg_state)
  );

`ifndef I_DECODER_BLANK_EN
  logic       rst1, en1, mode1, load1;
  logic [1:0] idx1;
  logic [3:0] y1;
  logic [1:0] cur1;
  logic       wrap1;
  logic [1:0] dbg_state1;

  i_decoder2_4_scan #(.SIZE(2), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .load(load1), .idx(idx1),
    .y(y1), .cur(cur1), .wrap(wrap1), .dbg_state(dbg_state1)
  );
`endif

  // ---------------- checker ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference 4-to-2 encoder: position of the single low bit.
  function automatic int enc(input logic [3:0] v);
    enc = -1;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) enc = i;
  endfunction

  // ---------------- behavioural model ----------------
  // mode_now: 0 idle, 1 direct, 2 scan. phase counts cycles spent on the current scan step.
  int m_mode = 0;
  int m_cur = 0;
  int m_phase = 0;
  bit m_wrap = 0;
  logic [8:0] exp_q[$];

  always @(posedge clk) begin : model
    int nmode;
    bit stepped;
    int ey;
    if (rst) begin
      m_mode = 0; m_cur = 0; m_phase = 0; m_wrap = 0;
    end else begin
      nmode = !en ? 0 : (mode ? 2 : 1);
      stepped = 0;
      if (load) begin
        m_cur = int'(idx);
        m_phase = 0;
      end else if (nmode == 2 && m_mode == 2) begin
        if (m_phase == DIV - 1) begin
          m_cur = (m_cur + 1) % 4;
          m_phase = 0;
          stepped = 1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      if (nmode != m_mode || nmode != 2) m_phase = 0;
      m_mode = nmode;
      m_wrap = stepped && (m_cur == 0);
    end
    ey = (m_mode == 0) ? 15 : (15 - (1 << m_cur));
    if (BLANK && m_mode == 2 && m_phase == 0) ey = 15;
    exp_q.push_back({m_mode[1:0], m_wrap, m_cur[1:0], ey[3:0]});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : scoreboard
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_y", int'(y), int'(e[3:0]));
      chk("sb_cur", int'(cur), int'(e[5:4]));
      chk("sb_wrap", int'(wrap), int'(e[6]));
      chk("sb_state", int'(dbg_state), int'(e[8:7]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(input logic [1:0] v);
    idx = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_model(input int want_cur, input int want_phase, input string tag);
    int n;
    n = 0;
    while (!(m_cur == want_cur && (want_phase < 0 || m_phase == want_phase)) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, int'(n >= 40), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ey;
    int wraps;
    rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0; idx = '0;
`ifndef I_DECODER_BLANK_EN
    rst1 = 1'b1; en1 = 1'b1; mode1 = 1'b1; load1 = 1'b0; idx1 = '0;
`endif
    tick(2);
    chk("rst_y", int'(y), 4'hF);
    chk("rst_cur", int'(cur), 0);
    chk("rst_wrap", int'(wrap), 0);
    rst = 1'b0;
    tick();
    chk("rst_release_y", int'(y), BLANK ? 4'hF : 4'hE);

    // Direct sweep
    mode = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_load(2'(i));
      chk("direct_y", int'(y), 15 - (1 << i));
      chk("direct_enc", enc(y), i);
      tick(4);
    end

    // Scan from cur=0 for 20 cycles
    do_load(2'd0);
    mode = 1'b1;
    tick();
    wraps = 0;
    for (int k = 0; k < 20; k++) begin
      ey = 15 - (1 << ((k / DIV) % 4));
      if (BLANK && (k % DIV) == 0) ey = 15;
      chk("scan_y", int'(y), ey);
      chk("scan_wrap", int'(wrap), int'(k == 16));
      wraps += int'(wrap);
      tick();
    end
    chk("scan_wrap_count", wraps, 1);

    // Load during scan at cur=1, prescaler=2
    wait_model(1, 2, "wait_cur1_psc2");
    do_load(2'd3);
    chk("scanload_cur", int'(cur), 3);
    chk("scanload_y", int'(y), BLANK ? 4'hF : 4'h7);
    chk("scanload_nowrap", int'(wrap), 0);
    tick(4);
    chk("scanload_step_cur", int'(cur), 0);
    chk("scanload_step_wrap", int'(wrap), 1);

    // en drop at cur=2
    wait_model(2, -1, "wait_cur2");
    en = 1'b0;
    tick();
    chk("endrop_y", int'(y), 4'hF);
    chk("endrop_cur", int'(cur), 2);
    tick(3);
    chk("idle_hold_cur", int'(cur), 2);
    en = 1'b1;
    tick();
    chk("reen_y", int'(y), BLANK ? 4'hF : 4'hB);
    tick(3);
    chk("reen_hold_cur", int'(cur), 2);
    tick();
    chk("reen_step_cur", int'(cur), 3);

    // Load coincident with en falling
    en = 1'b0;
    do_load(2'd1);
    chk("load_enfall_cur", int'(cur), 1);
    chk("load_enfall_y", int'(y), 4'hF);
    en = 1'b1;

    // Random traffic; the scoreboard checks every cycle
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      en   = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 99) < 6) mode = ~mode;
      load = ($urandom_range(0, 99) < 10);
      idx  = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; load = 1'b0;

`ifndef I_DECODER_BLANK_EN
    // DIV=1: one step per cycle after the SCAN entry edge
    rst1 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("div1_cur", int'(cur1), (k - 1) % 4);
      chk("div1_wrap", int'(wrap1), int'(k > 1 && ((k - 1) % 4) == 0));
      chk("div1_y", int'(y1), 15 - (1 << ((k - 1) % 4)));
    end
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
